// File: rtl/ame_num_expand.sv
// ---------------------------------------------------------------------------
// ame_num_expand
//   Pipelined inverse of the AME number approximator. Rebuilds the signed
//   integer +/-2^exp (or 0) at full data width from a sign/zero/exponent
//   triple. Three register stages (S0 capture, S1 byte-group decode,
//   S2 sign/saturation + output), one operand per cycle, stall freezes all.
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset (wins over stall)
//   comp_init_i   operand valid, sampled only when comp_stall_i = 0
//   comp_stall_i  hold every stage register including the outputs
//   comp_sign_i   1 = negative result
//   comp_zero_i   1 = result is 0 (overrides sign and exponent)
//   comp_exp_i    exponent e, magnitude 2^e
//   comp_done_o   result valid (S2 valid)
//   comp_sat_o    result was clamped to the maximum positive value
//   comp_data_o   signed two's-complement result
// ---------------------------------------------------------------------------
module ame_num_expand #(
    parameter int  COMP_DATA_BITS = 64,
    localparam int EXP_BITS       = $clog2(COMP_DATA_BITS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      comp_init_i,
    input  logic                      comp_stall_i,
    input  logic                      comp_sign_i,
    input  logic                      comp_zero_i,
    input  logic [EXP_BITS-1:0]       comp_exp_i,
    output logic                      comp_done_o,
    output logic                      comp_sat_o,
    output logic [COMP_DATA_BITS-1:0] comp_data_o
);

    localparam int NUM_BYTES = COMP_DATA_BITS / 8;

    // S0: captured inputs
    logic                      s0_vld_q;
    logic                      s0_sign_q;
    logic                      s0_zero_q;
    logic [EXP_BITS-1:0]       s0_exp_q;

    // S1: decoded magnitude
    logic                      s1_vld_q;
    logic                      s1_sign_q;
    logic                      s1_zero_q;
    logic [COMP_DATA_BITS-1:0] s1_mag_q;
    logic [COMP_DATA_BITS-1:0] s1_mag_d;

    // S2: output registers
    logic                      done_q;
    logic                      sat_q;
    logic [COMP_DATA_BITS-1:0] data_q;
    logic                      sat_d;
    logic [COMP_DATA_BITS-1:0] data_d;

    logic [NUM_BYTES-1:0]      byte_oh_s;
    logic [7:0]                bit_oh_s;

    // S1 decode: one-hot byte select times one-hot bit pattern within the byte
    always_comb begin
        byte_oh_s = {NUM_BYTES{1'b0}};
        byte_oh_s[s0_exp_q[EXP_BITS-1:3]] = 1'b1;
        bit_oh_s = 8'd0;
        bit_oh_s[s0_exp_q[2:0]] = 1'b1;
        s1_mag_d = {COMP_DATA_BITS{1'b0}};
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (byte_oh_s[i] && !s0_zero_q) begin
                s1_mag_d[i*8 +: 8] = bit_oh_s;
            end else begin
                s1_mag_d[i*8 +: 8] = 8'd0;
            end
        end
    end

    // S2 sign/saturation; outputs hold their last value when no result arrives
    always_comb begin
        data_d = data_q;
        sat_d  = sat_q;
        if (s1_vld_q) begin
            if (s1_zero_q) begin
                data_d = {COMP_DATA_BITS{1'b0}};
                sat_d  = 1'b0;
            end else if (s1_sign_q) begin
                // -2^(W-1) is representable, so negation never saturates
                data_d = (~s1_mag_q) + {{(COMP_DATA_BITS-1){1'b0}}, 1'b1};
                sat_d  = 1'b0;
            end else if (s1_mag_q[COMP_DATA_BITS-1]) begin
                // +2^(W-1) does not fit: clamp to the largest positive value
                data_d = {1'b0, {(COMP_DATA_BITS-1){1'b1}}};
                sat_d  = 1'b1;
            end else begin
                data_d = s1_mag_q;
                sat_d  = 1'b0;
            end
        end else begin
            data_d = data_q;
            sat_d  = sat_q;
        end
    end

    // Pipeline registers: reset clears all, stall holds all, else advance
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s0_vld_q  <= 1'b0;
            s0_sign_q <= 1'b0;
            s0_zero_q <= 1'b0;
            s0_exp_q  <= {EXP_BITS{1'b0}};
            s1_vld_q  <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_mag_q  <= {COMP_DATA_BITS{1'b0}};
            done_q    <= 1'b0;
            sat_q     <= 1'b0;
            data_q    <= {COMP_DATA_BITS{1'b0}};
        end else if (!comp_stall_i) begin
            s0_vld_q  <= comp_init_i;
            s0_sign_q <= comp_sign_i;
            s0_zero_q <= comp_zero_i;
            s0_exp_q  <= comp_exp_i;
            s1_vld_q  <= s0_vld_q;
            s1_sign_q <= s0_sign_q;
            s1_zero_q <= s0_zero_q;
            s1_mag_q  <= s1_mag_d;
            done_q    <= s1_vld_q;
            sat_q     <= sat_d;
            data_q    <= data_d;
        end
    end

    assign comp_done_o = done_q;
    assign comp_sat_o  = sat_q;
    assign comp_data_o = data_q;

endmodule
